ifm_feeder: RTL and testbench

- Host-side input-feature-map source for the CNN accelerator top.
- Buffers one complete input image (CI channels of IFM_SIZE x IFM_SIZE words) loaded by the host, then issues the start_conv pulse.
- Answers the accelerator's ifm_read request strobes with one word per request on the ifm bus, so it is the responder end of the ifm_read/ifm pull interface.
- Supports re-streaming the image PASSES times and reports completion when the accelerator's end_op arrives.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/feeder_mem.sv | 34 +++
 rtl/ifm_feeder.sv | 179 +++++++++++++++++
 tb/tb_ifm_feeder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator host-side blocks.
//   - feeder_state_e : state encoding of the input-feature-map feeder
//   - clog2()        : constant address-width helper (never returns less than 1)
//   - IFM_WIDTH_DEF  : default feature-map word width
package cnn_pkg;

  localparam int IFM_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_KICK   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  // A 1-deep buffer or a single-valued counter still needs a 1-bit register.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/feeder_mem.sv
// Simple dual-port synchronous RAM holding one input image.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write word
//   i_rd_en    : read strobe; o_rd_data updates on the next edge only when set
//   i_rd_addr  : read address
//   o_rd_data  : registered read word; holds its value between reads
// The array has no reset; the parent masks o_rd_data where a zero is required.
module feeder_mem
  import cnn_pkg::*;
#(
  parameter int WIDTH = IFM_WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/ifm_feeder.sv
// Host-side input-feature-map source for the CNN accelerator.
// Buffers one image loaded by the host (channel-major, row-major), kicks the
// accelerator with a one-cycle start pulse, then answers each ifm_read request
// with the next word one cycle later. The image may be swept PASSES times;
// further requests are flagged as underruns and return zero.
//
// state  | meaning
// IDLE   | accepting host words into the buffer
// READY  | buffer full, waiting for host_start
// KICK   | one cycle, start_conv pulse, reads already honoured
// STREAM | serving ifm_read requests until end_op
// DONE   | frame finished; host_start re-runs, clear empties
//
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_load_en/_data    : host write strobe and word
//   i_host_start       : start (or re-run) request
//   i_clear            : abort, empty buffer, clear error flags
//   o_loaded, o_busy, o_done, o_ovf_err, o_udr_err : status
//   o_start_conv       : one-cycle start pulse to the accelerator
//   i_ifm_read / o_ifm : accelerator pull request and returned word
//   i_end_op           : accelerator frame-complete pulse
module ifm_feeder
  import cnn_pkg::*;
#(
  parameter int IFM_WIDTH = IFM_WIDTH_DEF,
  parameter int IFM_SIZE  = 27,
  parameter int CI        = 3,
  parameter int PASSES    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load_en,
  input  logic [IFM_WIDTH-1:0] i_load_data,
  input  logic                 i_host_start,
  input  logic                 i_clear,
  output logic                 o_loaded,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ovf_err,
  output logic                 o_udr_err,
  output logic                 o_start_conv,
  input  logic                 i_ifm_read,
  output logic [IFM_WIDTH-1:0] o_ifm,
  input  logic                 i_end_op
);

  localparam int DEPTH = CI * IFM_SIZE * IFM_SIZE;
  localparam int AW    = clog2(DEPTH);
  localparam int PW    = clog2(PASSES + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0] PASS_LIM  = PW'(PASSES);

  feeder_state_e r_state, w_next;

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_pass_cnt;
  logic                 r_ovf_err;
  logic                 r_udr_err;
  logic                 r_ifm_zero;
  logic                 w_wr_en;
  logic                 w_rd_req;
  logic                 w_underrun;
  logic                 w_rd_en;
  logic                 w_restart;
  logic [IFM_WIDTH-1:0] w_rd_data;

  // Requests are honoured from the KICK cycle on; reset and clear win over all.
  assign w_rd_req   = i_rst_n && !i_clear && i_ifm_read &&
                      (r_state == ST_KICK || r_state == ST_STREAM);
  assign w_underrun = w_rd_req && (r_pass_cnt == PASS_LIM);
  assign w_rd_en    = w_rd_req && !w_underrun;
  assign w_wr_en    = i_rst_n && !i_clear && i_load_en && (r_state == ST_IDLE);
  assign w_restart  = !i_clear && i_host_start && (r_state == ST_DONE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    o_loaded     = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_start_conv = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_en && r_wr_ptr == LAST_ADDR) w_next = ST_READY;
      end
      ST_READY: begin
        o_loaded = 1'b1;
        if (i_host_start) w_next = ST_KICK;
      end
      ST_KICK: begin
        o_loaded     = 1'b1;
        o_busy       = 1'b1;
        o_start_conv = 1'b1;
        w_next       = ST_STREAM;
      end
      ST_STREAM: begin
        o_loaded = 1'b1;
        o_busy   = 1'b1;
        if (i_end_op) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_loaded = 1'b1;
        o_done   = 1'b1;
        if (i_host_start) w_next = ST_KICK;
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_clear) w_next = ST_IDLE;
  end

  // Pointers, pass counter, sticky errors and the read-data mask.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
      r_ovf_err  <= 1'b0;
      r_udr_err  <= 1'b0;
      r_ifm_zero <= 1'b1;
    end else begin
      // DEPTH need not be a power of two, so the wrap is explicit.
      if (w_wr_en) begin
        if (r_wr_ptr == LAST_ADDR) r_wr_ptr <= '0;
        else                       r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (i_load_en && r_state != ST_IDLE) r_ovf_err <= 1'b1;

      if (w_restart) begin
        r_rd_ptr   <= '0;
        r_pass_cnt <= '0;
      end else if (w_rd_en) begin
        if (r_rd_ptr == LAST_ADDR) begin
          r_rd_ptr   <= '0;
          r_pass_cnt <= r_pass_cnt + PW'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end

      // The RAM output only moves on a served read, so the mask alone gives
      // both the zero after an underrun and the hold between requests.
      if (w_underrun) begin
        r_udr_err  <= 1'b1;
        r_ifm_zero <= 1'b1;
      end else if (w_rd_en) begin
        r_ifm_zero <= 1'b0;
      end
    end
  end

  feeder_mem #(
    .WIDTH (IFM_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_load_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign o_ifm     = r_ifm_zero ? '0 : w_rd_data;
  assign o_ovf_err = r_ovf_err;
  assign o_udr_err = r_udr_err;

endmodule

// File: tb/tb_ifm_feeder.sv
// Directed bench for ifm_feeder with a 2x2x1 image swept twice.
// Each vector drives the inputs for one cycle and states the outputs expected
// just after the following rising edge.
module tb_ifm_feeder;

  logic        clk = 1'b0;
  logic        rst_n, load_en, host_start, clear, ifm_read, end_op;
  logic [31:0] load_data;
  logic        loaded, busy, done, ovf_err, udr_err, start_conv;
  logic [31:0] ifm;

  always #5 clk = ~clk;

  ifm_feeder #(
    .IFM_WIDTH (32),
    .IFM_SIZE  (2),
    .CI        (1),
    .PASSES    (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_en    (load_en),
    .i_load_data  (load_data),
    .i_host_start (host_start),
    .i_clear      (clear),
    .o_loaded     (loaded),
    .o_busy       (busy),
    .o_done       (done),
    .o_ovf_err    (ovf_err),
    .o_udr_err    (udr_err),
    .o_start_conv (start_conv),
    .i_ifm_read   (ifm_read),
    .o_ifm        (ifm),
    .i_end_op     (end_op)
  );

  // input bits: {rst_n, load_en, host_start, clear, ifm_read, end_op}
  localparam logic [5:0] RUN = 6'b100000;
  localparam logic [5:0] LD  = 6'b010000;
  localparam logic [5:0] ST  = 6'b001000;
  localparam logic [5:0] CL  = 6'b000100;
  localparam logic [5:0] RD  = 6'b000010;
  localparam logic [5:0] EO  = 6'b000001;
  // expected bits: {loaded, busy, done, ovf_err, udr_err, start_conv}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LO   = 6'b100000;
  localparam logic [5:0] BZ   = 6'b010000;
  localparam logic [5:0] DN   = 6'b001000;
  localparam logic [5:0] OV   = 6'b000100;
  localparam logic [5:0] UD   = 6'b000010;
  localparam logic [5:0] SC   = 6'b000001;

  typedef struct {
    string       name;
    logic [5:0]  in_bits;
    logic [31:0] data;
    logic [5:0]  exp_bits;
    logic [31:0] exp_ifm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string n, input logic [5:0] i, input logic [31:0] d,
                              input logic [5:0] e, input logic [31:0] q);
    vec_t v;
    v.name = n; v.in_bits = i; v.data = d; v.exp_bits = e; v.exp_ifm = q;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [5:0] got;
    {rst_n, load_en, host_start, clear, ifm_read, end_op} = v.in_bits;
    load_data = v.data;
    @(posedge clk);
    #1;
    got = {loaded, busy, done, ovf_err, udr_err, start_conv};
    n_vec++;
    if (got !== v.exp_bits || ifm !== v.exp_ifm) begin
      n_bad++;
      $display("FAIL %s: flags(loaded,busy,done,ovf,udr,start) got %b want %b, ifm got %h want %h",
               v.name, got, v.exp_bits, ifm, v.exp_ifm);
    end
  endtask

  initial begin
    {rst_n, load_en, host_start, clear, ifm_read, end_op} = 6'b0;
    load_data = '0;

    // Main flow: load, kick, two sweeps, underrun, end_op, re-run, clear.
    tbl.push_back(mk("reset",          NONE,      0, NONE,           32'h0));
    tbl.push_back(mk("idle",           RUN,       0, NONE,           32'h0));
    tbl.push_back(mk("start_in_idle",  RUN|ST,    0, NONE,           32'h0));
    tbl.push_back(mk("load0",          RUN|LD,  'hA, NONE,           32'h0));
    tbl.push_back(mk("load1",          RUN|LD,  'hB, NONE,           32'h0));
    tbl.push_back(mk("load2",          RUN|LD,  'hC, NONE,           32'h0));
    tbl.push_back(mk("load3_full",     RUN|LD,  'hD, LO,             32'h0));
    tbl.push_back(mk("eop_in_ready",   RUN|EO,    0, LO,             32'h0));
    tbl.push_back(mk("kick",           RUN|ST,    0, LO|BZ|SC,       32'h0));
    tbl.push_back(mk("rd_in_kick",     RUN|RD,    0, LO|BZ,          32'hA));
    tbl.push_back(mk("rd_b",           RUN|RD,    0, LO|BZ,          32'hB));
    tbl.push_back(mk("rd_c",           RUN|RD,    0, LO|BZ,          32'hC));
    tbl.push_back(mk("rd_d_wrap",      RUN|RD,    0, LO|BZ,          32'hD));
    tbl.push_back(mk("hold_d0",        RUN,       0, LO|BZ,          32'hD));
    tbl.push_back(mk("hold_d1",        RUN,       0, LO|BZ,          32'hD));
    tbl.push_back(mk("p2_rd_a",        RUN|RD,    0, LO|BZ,          32'hA));
    tbl.push_back(mk("p2_hold_a",      RUN,       0, LO|BZ,          32'hA));
    tbl.push_back(mk("p2_rd_b",        RUN|RD,    0, LO|BZ,          32'hB));
    tbl.push_back(mk("p2_rd_c",        RUN|RD,    0, LO|BZ,          32'hC));
    tbl.push_back(mk("p2_hold_c",      RUN,       0, LO|BZ,          32'hC));
    tbl.push_back(mk("p2_rd_d",        RUN|RD,    0, LO|BZ,          32'hD));
    tbl.push_back(mk("p2_hold_d",      RUN,       0, LO|BZ,          32'hD));
    tbl.push_back(mk("udr_first",      RUN|RD,    0, LO|BZ|UD,       32'h0));
    tbl.push_back(mk("udr_sticky",     RUN,       0, LO|BZ|UD,       32'h0));
    tbl.push_back(mk("udr_second",     RUN|RD,    0, LO|BZ|UD,       32'h0));
    tbl.push_back(mk("udr_idle",       RUN,       0, LO|BZ|UD,       32'h0));
    tbl.push_back(mk("udr_third",      RUN|RD,    0, LO|BZ|UD,       32'h0));
    tbl.push_back(mk("eop_stream",     RUN|EO,    0, LO|DN|UD,       32'h0));
    tbl.push_back(mk("rd_in_done",     RUN|RD,    0, LO|DN|UD,       32'h0));
    tbl.push_back(mk("rerun_kick",     RUN|ST,    0, LO|BZ|UD|SC,    32'h0));
    tbl.push_back(mk("rerun_rd_a",     RUN|RD,    0, LO|BZ|UD,       32'hA));
    tbl.push_back(mk("rd_with_eop",    RUN|RD|EO, 0, LO|DN|UD,       32'hB));
    tbl.push_back(mk("done_hold",      RUN,       0, LO|DN|UD,       32'hB));
    tbl.push_back(mk("clear_done",     RUN|CL,    0, NONE,           32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // Overflow in READY must not disturb mem[0]; clear wipes errors and blocks loads.
    apply(mk("ovf_load0",       RUN|LD,   'hA,  NONE,        32'h0));
    apply(mk("ovf_load1",       RUN|LD,   'hB,  NONE,        32'h0));
    apply(mk("ovf_load2",       RUN|LD,   'hC,  NONE,        32'h0));
    apply(mk("ovf_load3",       RUN|LD,   'hD,  LO,          32'h0));
    apply(mk("ovf_5th_load",    RUN|LD,   'h55, LO|OV,       32'h0));
    apply(mk("ovf_kick",        RUN|ST,   0,    LO|BZ|OV|SC, 32'h0));
    apply(mk("ovf_rd_a",        RUN|RD,   0,    LO|BZ|OV,    32'hA));
    apply(mk("ovf_load_stream", RUN|LD|RD,'h77, LO|BZ|OV,    32'hB));
    apply(mk("ovf_clear",       RUN|CL,   0,    NONE,        32'h0));
    apply(mk("clear_vs_load",   RUN|CL|LD,'h99, NONE,        32'h0));

    // Reset in the middle of a stream, then a fresh image.
    apply(mk("rs_load0",        RUN|LD,   'hA,  NONE,        32'h0));
    apply(mk("rs_load1",        RUN|LD,   'hB,  NONE,        32'h0));
    apply(mk("rs_load2",        RUN|LD,   'hC,  NONE,        32'h0));
    apply(mk("rs_load3",        RUN|LD,   'hD,  LO,          32'h0));
    apply(mk("rs_kick",         RUN|ST,   0,    LO|BZ|SC,    32'h0));
    apply(mk("rs_rd_a",         RUN|RD,   0,    LO|BZ,       32'hA));
    apply(mk("rs_rd_b",         RUN|RD,   0,    LO|BZ,       32'hB));
    apply(mk("rs_mid_stream",   RD|EO|ST, 0,    NONE,        32'h0));
    apply(mk("rs_reload1",      RUN|LD,   'h1,  NONE,        32'h0));
    apply(mk("rs_reload2",      RUN|LD,   'h2,  NONE,        32'h0));
    apply(mk("rs_reload3",      RUN|LD,   'h3,  NONE,        32'h0));
    apply(mk("rs_reload4",      RUN|LD,   'h4,  LO,          32'h0));
    apply(mk("rs_kick2",        RUN|ST,   0,    LO|BZ|SC,    32'h0));
    apply(mk("rs_first_word",   RUN|RD,   0,    LO|BZ,       32'h1));
    apply(mk("rs_end",          RUN|EO,   0,    LO|DN,       32'h1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
